// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//   Bridges the execute-stage data-memory access port onto an SRAM-like bus
//   with split address/data handshakes. Only one access is outstanding at a
//   time: IDLE -> REQ (bus_req held until bus_addr_ok) -> WAIT (until
//   bus_data_ok) -> RESP (one-cycle ex_rvalid) -> IDLE. A pipeline flush
//   cannot withdraw a bus request that is already out; it only marks the
//   access cancelled so its response is swallowed.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   flush             pipeline flush, cancels the in-flight response
//   ex_valid/ex_we/ex_addr/ex_wdata/ex_wstrb   execute-stage request
//   ex_ready          high only in IDLE
//   ex_rvalid/ex_rdata  completion pulse and load data (0 for stores)
//   bus_req/bus_wr/bus_addr/bus_wdata/bus_wstrb  bus request side
//   bus_addr_ok/bus_data_ok/bus_rdata            bus response side
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ex_valid,
  input  logic                    ex_we,
  input  logic [ADDR_WIDTH-1:0]   ex_addr,
  input  logic [DATA_WIDTH-1:0]   ex_wdata,
  input  logic [DATA_WIDTH/8-1:0] ex_wstrb,
  output logic                    ex_ready,
  output logic                    ex_rvalid,
  output logic [DATA_WIDTH-1:0]   ex_rdata,
  output logic                    bus_req,
  output logic                    bus_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  input  logic                    bus_addr_ok,
  input  logic                    bus_data_ok,
  input  logic [DATA_WIDTH-1:0]   bus_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    cancel_r;
  logic                    cancel_s;
  logic                    accept_s;
  logic                    drop_s;
  logic                    we_r;
  logic [ADDR_WIDTH-3:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_WIDTH-1:0]   wstrb_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    addr_lsb_unused_s;

  // The bus is word addressed; the byte offset is carried by the strobes.
  assign addr_lsb_unused_s = ^ex_addr[1:0];

  assign accept_s = ex_valid && (state_r == IDLE) && !flush;
  // A flush arriving in the same cycle as data_ok still kills the response.
  assign drop_s   = cancel_r || flush;

  // State and cancel-flag register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      cancel_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cancel_r <= cancel_s;
    end
  end

  // Next-state and cancel-flag logic.
  always_comb begin
    state_s  = state_r;
    cancel_s = cancel_r;
    case (state_r)
      IDLE: begin
        cancel_s = 1'b0;
        if (accept_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        cancel_s = drop_s;
        // bus_req is never withdrawn before the bus accepts it.
        if (bus_addr_ok) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        cancel_s = drop_s;
        if (bus_data_ok) begin
          if (drop_s) begin
            state_s = IDLE;
          end else begin
            state_s = RESP;
          end
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s  = IDLE;
        cancel_s = cancel_r;
      end
      default: begin
        state_s  = IDLE;
        cancel_s = 1'b0;
      end
    endcase
  end

  // Request latch and response data register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_r    <= 1'b0;
      addr_r  <= {(ADDR_WIDTH-2){1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      wstrb_r <= {STRB_WIDTH{1'b0}};
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        we_r    <= ex_we;
        addr_r  <= ex_addr[ADDR_WIDTH-1:2];
        wdata_r <= ex_wdata;
        // Loads never present byte enables on the bus.
        wstrb_r <= ex_we ? ex_wstrb : {STRB_WIDTH{1'b0}};
      end else begin
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        wstrb_r <= wstrb_r;
      end
      if ((state_r == WAIT) && bus_data_ok && !drop_s) begin
        rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : bus_rdata;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign ex_ready  = (state_r == IDLE);
  assign ex_rvalid = (state_r == RESP) && !flush;
  assign ex_rdata  = rdata_r;
  assign bus_req   = (state_r == REQ);
  assign bus_wr    = we_r;
  assign bus_addr  = {addr_r, 2'b00};
  assign bus_wdata = wdata_r;
  assign bus_wstrb = wstrb_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//   Directed self-checking bench for dmem_bridge. Inputs are driven just after
//   the falling edge, outputs sampled 1 ns later; expected responses are queued
//   at acceptance and popped when ex_rvalid is observed.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_we;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_wstrb;
  logic        ex_ready;
  logic        ex_rvalid;
  logic [31:0] ex_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_wstrb(ex_wstrb),
    .ex_ready(ex_ready), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Checks ex_rvalid; on a pulse, pops the scoreboard and checks ex_rdata.
  task automatic chk_resp(input string tag, input logic exp_v);
    chk({tag, "_rvalid"}, 32'(ex_rvalid), 32'(exp_v));
    if (ex_rvalid === 1'b1) begin
      chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk({tag, "_rdata"}, ex_rdata, sb_q.pop_front());
    end
  endtask

  // Next cycle: wait for the falling edge and return control inputs to idle.
  task automatic go();
    @(negedge clk);
    ex_valid    = 1'b0;
    flush       = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  // Stable store-field check used while the store sits in REQ.
  task automatic chk_store_fields(input string tag);
    chk({tag, "_req"},   32'(bus_req),   32'd1);
    chk({tag, "_wr"},    32'(bus_wr),    32'd1);
    chk({tag, "_addr"},  bus_addr,       32'h0000_1000);
    chk({tag, "_wdata"}, bus_wdata,      32'h0000_00AB);
    chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'h1);
  endtask

  initial begin
    int          acc;
    logic        wait_f;
    logic        resp_f;
    logic [31:0] exp_a;

    rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_we = 1'b0;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_wstrb = 4'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready",  32'(ex_ready),  32'd1);
    chk("rst_rvalid", 32'(ex_rvalid), 32'd0);
    chk("rst_rdata",  ex_rdata,       32'h0);
    chk("rst_req",    32'(bus_req),   32'd0);
    chk("rst_wr",     32'(bus_wr),    32'd0);
    chk("rst_addr",   bus_addr,       32'h0);
    chk("rst_wdata",  bus_wdata,      32'h0);
    chk("rst_wstrb",  32'(bus_wstrb), 32'h0);
    rst = 1'b1;

    // Zero-wait load.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h1C00_0006; ex_wstrb = 4'hF; #1;
    chk("ld_accept_ready", 32'(ex_ready), 32'd1);
    sb_q.push_back(32'hDEAD_BEEF);
    go(); bus_addr_ok = 1'b1; #1;
    chk("ld_req",   32'(bus_req),   32'd1);
    chk("ld_addr",  bus_addr,       32'h1C00_0004);
    chk("ld_wstrb", 32'(bus_wstrb), 32'h0);
    chk("ld_wr",    32'(bus_wr),    32'd0);
    chk("ld_busy",  32'(ex_ready),  32'd0);
    chk_resp("ld_t1", 1'b0);
    go(); bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("ld_wait_noreq", 32'(bus_req), 32'd0);
    chk_resp("ld_t2", 1'b0);
    go(); #1;
    chk_resp("ld_t3", 1'b1);
    go(); #1;
    chk("ld_t4_ready", 32'(ex_ready), 32'd1);
    chk_resp("ld_t4", 1'b0);

    // Store with addr_ok held low for 3 cycles.
    go(); ex_valid = 1'b1; ex_we = 1'b1; ex_addr = 32'h0000_1002;
    ex_wdata = 32'h0000_00AB; ex_wstrb = 4'b0001; #1;
    chk("st_accept_ready", 32'(ex_ready), 32'd1);
    sb_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      go(); #1;
      chk_store_fields("st_stall");
    end
    go(); bus_addr_ok = 1'b1; #1;
    chk_store_fields("st_aok");
    go(); bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF; #1;
    chk("st_wait_noreq", 32'(bus_req), 32'd0);
    chk_resp("st_wait", 1'b0);
    go(); #1;
    chk_resp("st_resp", 1'b1);
    go(); #1;
    chk("st_ready", 32'(ex_ready), 32'd1);
    chk_resp("st_after", 1'b0);

    // Request with flush in IDLE is ignored.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0500; flush = 1'b1; #1;
    chk("fidle_ready", 32'(ex_ready), 32'd1);
    go(); #1;
    chk("fidle_still_idle", 32'(ex_ready), 32'd1);
    chk("fidle_noreq",      32'(bus_req),  32'd0);

    // Flush in WAIT on a load: waits for data_ok, no response.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0020; #1;
    go(); bus_addr_ok = 1'b1; #1;
    go(); flush = 1'b1; #1;
    chk_resp("fwait_t2", 1'b0);
    go(); #1;
    chk("fwait_busy", 32'(ex_ready), 32'd0);
    chk_resp("fwait_t3", 1'b0);
    go(); bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678; #1;
    chk("fwait_busy_dok", 32'(ex_ready), 32'd0);
    go(); #1;
    chk("fwait_ready", 32'(ex_ready), 32'd1);
    chk_resp("fwait_t5", 1'b0);

    // Flush in REQ with addr_ok low; a stray data_ok in REQ is ignored.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0030; #1;
    go(); flush = 1'b1; #1;
    chk("freq_t1_req", 32'(bus_req), 32'd1);
    go(); bus_data_ok = 1'b1; #1;
    chk("freq_t2_req", 32'(bus_req), 32'd1);
    go(); bus_addr_ok = 1'b1; #1;
    chk("freq_t3_req", 32'(bus_req), 32'd1);
    go(); bus_data_ok = 1'b1; #1;
    chk("freq_t4_noreq", 32'(bus_req), 32'd0);
    chk_resp("freq_t4", 1'b0);
    go(); #1;
    chk("freq_ready", 32'(ex_ready), 32'd1);
    chk_resp("freq_t5", 1'b0);

    // Flush coincident with RESP.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0040; #1;
    go(); bus_addr_ok = 1'b1; #1;
    go(); bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D; #1;
    go(); flush = 1'b1; #1;
    chk_resp("fresp_t3", 1'b0);
    go(); #1;
    chk("fresp_ready", 32'(ex_ready), 32'd1);
    chk_resp("fresp_t4", 1'b0);

    // data_ok on the cycle WAIT is entered is not sampled.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0080; #1;
    sb_q.push_back(32'h55AA_55AA);
    go(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111; #1;
    go(); #1;
    chk("early_dok_wait", 32'(ex_ready), 32'd0);
    chk_resp("early_dok_t2", 1'b0);
    go(); bus_data_ok = 1'b1; bus_rdata = 32'h55AA_55AA; #1;
    chk_resp("early_dok_t3", 1'b0);
    go(); #1;
    chk_resp("early_dok_t4", 1'b1);
    go(); bus_data_ok = 1'b1; #1;
    chk("idle_dok_ready", 32'(ex_ready), 32'd1);
    go(); #1;
    chk("idle_dok_still", 32'(ex_ready), 32'd1);
    chk_resp("idle_dok", 1'b0);

    // Back-to-back: ex_valid held high against a zero-wait bus model.
    acc = 0; wait_f = 1'b0; resp_f = 1'b0;
    for (int c = 0; c < 16; c++) begin
      go();
      ex_valid = 1'b1; ex_we = 1'b0;
      ex_addr  = 32'h0000_3001 + 32'(acc) * 32'd4;
      if (wait_f) begin
        bus_data_ok = 1'b1;
        bus_rdata   = bus_addr ^ 32'hA5A5_A5A5;
      end
      #1;
      chk_resp("b2b", resp_f);
      resp_f = wait_f;
      wait_f = 1'b0;
      if (ex_ready === 1'b1) begin
        sb_q.push_back((ex_addr & 32'hFFFF_FFFC) ^ 32'hA5A5_A5A5);
        addr_q.push_back(ex_addr & 32'hFFFF_FFFC);
        acc++;
      end
      if (bus_req === 1'b1) begin
        bus_addr_ok = 1'b1;
        wait_f      = 1'b1;
        chk("b2b_addrq_nonempty", 32'(addr_q.size() > 0), 32'd1);
        if (addr_q.size() > 0) begin
          exp_a = addr_q.pop_front();
          chk("b2b_addr", bus_addr, exp_a);
        end
      end
    end
    go(); #1;
    chk("b2b_accepts", 32'(acc), 32'd4);
    chk("b2b_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset in WAIT abandons the access; a later data_ok is ignored.
    go(); ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h0000_0700; #1;
    go(); bus_addr_ok = 1'b1; #1;
    go(); rst = 1'b0; #1;
    go(); rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999; #1;
    chk("rstmid_ready", 32'(ex_ready), 32'd1);
    chk("rstmid_addr",  bus_addr,      32'h0);
    chk_resp("rstmid_t3", 1'b0);
    go(); #1;
    chk("rstmid_idle", 32'(ex_ready), 32'd1);
    chk_resp("rstmid_t4", 1'b0);

    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
